unidade_controle_pilha: RTL
===========================

// Module: unidade_controle_pilha
// PURPOSE
//  Stack control unit feeding the register bank: executes PUSH/POP, sequences the data-memory access,
//  computes the new $rp and drives PilhaE/rp into the bank for exactly one cycle per completed op.
//  Holds the authoritative $rp copy; the stack grows downward from RP_INIT toward STACK_LIMIT.
// PARAMETERS
//  DATA_W       32   data / memory word width
//  RP_INIT      25   $rp after reset (empty stack; equals the bank's boot value of $rp)
//  STACK_LIMIT  0    lowest legal $rp; a PUSH with $rp == STACK_LIMIT overflows
// PORTS
//  clock        in   1       single clock; all state changes on posedge
//  reset_n      in   1       asynchronous, active-low reset
//  op_valid     in   1       stack op request
//  op_ready     out  1       1 only in IDLE; op accepted on posedge with op_valid & op_ready
//  op_code      in   2       00 PUSH, 01 POP, 10 RELOAD (rp <- RP_INIT), 11 reserved
//  push_dado    in   DATA_W  PUSH data, captured at acceptance
//  mem_req      out  1       memory request, held until mem_ack
//  mem_we       out  1       1 = write (PUSH), 0 = read (POP)
//  mem_addr     out  DATA_W  word address
//  mem_wdata    out  DATA_W  write data
//  mem_rdata    in   DATA_W  read data, valid with mem_ack
//  mem_ack      in   1       access complete; ignored while mem_req = 0
//  rp           out  DATA_W  current $rp (to bank rp input)
//  PilhaE       out  1       bank write-enable for $rp, one full cycle per successful PUSH/POP/RELOAD
//  pop_dado     out  DATA_W  popped word, valid while pop_valid
//  pop_valid    out  1       one-cycle strobe for the popped word
//  op_done      out  1       one-cycle strobe: op finished (success or error)
//  erro_overflow  out 1      sticky; cleared by clr_erro or reset
//  erro_underflow out 1      sticky; cleared by clr_erro or reset
//  clr_erro     in   1       synchronous clear of both error flags (set takes priority in same cycle)
// BEHAVIOUR
//  Reset: state IDLE, rp = RP_INIT, mem_req/mem_we/PilhaE/pop_valid/op_done/errors = 0, mem_addr/
//   mem_wdata/pop_dado = 0. Async reset mid-access abandons the transaction; mem_req drops immediately.
//  FSM IDLE -> ACESSO -> CONCLUI -> IDLE; all outputs registered (stable across the bank's negedge).
//  IDLE, accept PUSH: rp == STACK_LIMIT -> CONCLUI with erro_overflow set, no memory access, rp unchanged;
//   else mem_req=1, mem_we=1, mem_addr=rp-1, mem_wdata=push_dado -> ACESSO.
//  IDLE, accept POP: rp == RP_INIT -> CONCLUI with erro_underflow set, no access;
//   else mem_req=1, mem_we=0, mem_addr=rp -> ACESSO.
//  IDLE, accept RELOAD: rp <= RP_INIT, PilhaE=1 -> CONCLUI. Reserved code: CONCLUI, no side effects.
//  ACESSO: mem_req and address/data held stable until posedge with mem_ack=1; on that edge mem_req<=0,
//   rp <= rp-1 (PUSH) or rp+1 (POP), PilhaE<=1, POP also pop_dado<=mem_rdata, pop_valid<=1 -> CONCLUI.
//  CONCLUI: op_done=1 for this single cycle (plus PilhaE/pop_valid if set); next edge -> IDLE, strobes 0.
//  Latency with zero-wait memory (ack first cycle of mem_req): accept edge E0, ack edge E1,
//   PilhaE/op_done high E1..E2, op_ready high again after E2 (3 cycles per op). Each wait cycle adds 1.
//  Error ops: op_done at E1, rp and PilhaE untouched. Flags sticky across later successful ops.
//  rp arithmetic modulo 2^DATA_W; limits checked before access so wrap never occurs in legal use.
//  op_valid while op_ready=0 is ignored (requester must hold it). mem_ack in IDLE/CONCLUI ignored.
// STRUCTURE
//  Shared package pilha_pkg: op_code constants (OP_PUSH, OP_POP, OP_RELOAD), FSM state encoding.
//  Single flat module; no sub-module (limit compare and rp adder are inline).
// TESTING
//  Reset then PUSH 0xDEADBEEF, ack immediately -> mem_addr=24, mem_we=1; rp=24, PilhaE 1 cycle, op_done.
//  POP after that, ack after 3 wait cycles -> mem_addr=24 held 4 cycles; pop_dado=0xDEADBEEF, rp=25.
//  POP at rp=25 -> no mem_req, erro_underflow=1, op_done, rp=25; stays 1 until clr_erro pulse.
//  STACK_LIMIT=23: 2 PUSHes ok (rp=23), third -> erro_overflow, rp=23, no memory write.
//  reset_n low while ACESSO with mem_req high -> mem_req=0 at once, rp=25, op_ready=1 after release.
//  PUSH,PUSH,RELOAD -> rp 24,23 then 25 with PilhaE each time; back-to-back op_valid accepted every 3 cycles.

Source files
------------

// File: rtl/pilha_pkg.sv
// Shared definitions for the stack control unit: operation codes and FSM state encoding.
package pilha_pkg;

    localparam logic [1:0] OP_PUSH   = 2'b00;
    localparam logic [1:0] OP_POP    = 2'b01;
    localparam logic [1:0] OP_RELOAD = 2'b10;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        ACESSO  = 2'b01,
        CONCLUI = 2'b10
    } estado_t;

endpackage

// File: rtl/unidade_controle_pilha.sv
// Stack control unit: runs PUSH/POP/RELOAD, sequences the data-memory access and owns $rp.
// All outputs are registered so they stay stable across the register bank's negedge write.
module unidade_controle_pilha
    import pilha_pkg::*;
#(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned RP_INIT     = 25,
    parameter int unsigned STACK_LIMIT = 0
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              op_valid,
    output logic              op_ready,
    input  logic [1:0]        op_code,
    input  logic [DATA_W-1:0] push_dado,
    output logic              mem_req,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic [DATA_W-1:0] rp,
    output logic              PilhaE,
    output logic [DATA_W-1:0] pop_dado,
    output logic              pop_valid,
    output logic              op_done,
    output logic              erro_overflow,
    output logic              erro_underflow,
    input  logic              clr_erro
);

    localparam logic [DATA_W-1:0] RP_RESET = DATA_W'(RP_INIT);
    localparam logic [DATA_W-1:0] RP_LIMIT = DATA_W'(STACK_LIMIT);
    localparam logic [DATA_W-1:0] UM       = DATA_W'(1);

    estado_t estado;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            estado         <= IDLE;
            op_ready       <= 1'b1;
            rp             <= RP_RESET;
            mem_req        <= 1'b0;
            mem_we         <= 1'b0;
            mem_addr       <= '0;
            mem_wdata      <= '0;
            PilhaE         <= 1'b0;
            pop_dado       <= '0;
            pop_valid      <= 1'b0;
            op_done        <= 1'b0;
            erro_overflow  <= 1'b0;
            erro_underflow <= 1'b0;
        end else begin
            PilhaE    <= 1'b0;
            pop_valid <= 1'b0;
            op_done   <= 1'b0;

            // Clear first so a flag set below in the same cycle wins.
            if (clr_erro) begin
                erro_overflow  <= 1'b0;
                erro_underflow <= 1'b0;
            end

            case (estado)
                IDLE: begin
                    if (op_valid) begin
                        op_ready <= 1'b0;
                        case (op_code)
                            OP_PUSH: begin
                                if (rp == RP_LIMIT) begin
                                    erro_overflow <= 1'b1;
                                    op_done       <= 1'b1;
                                    estado        <= CONCLUI;
                                end else begin
                                    mem_req   <= 1'b1;
                                    mem_we    <= 1'b1;
                                    mem_addr  <= rp - UM;
                                    mem_wdata <= push_dado;
                                    estado    <= ACESSO;
                                end
                            end
                            OP_POP: begin
                                if (rp == RP_RESET) begin
                                    erro_underflow <= 1'b1;
                                    op_done        <= 1'b1;
                                    estado         <= CONCLUI;
                                end else begin
                                    mem_req  <= 1'b1;
                                    mem_we   <= 1'b0;
                                    mem_addr <= rp;
                                    estado   <= ACESSO;
                                end
                            end
                            OP_RELOAD: begin
                                rp      <= RP_RESET;
                                PilhaE  <= 1'b1;
                                op_done <= 1'b1;
                                estado  <= CONCLUI;
                            end
                            default: begin
                                op_done <= 1'b1;
                                estado  <= CONCLUI;
                            end
                        endcase
                    end
                end
                ACESSO: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        PilhaE  <= 1'b1;
                        op_done <= 1'b1;
                        if (mem_we) begin
                            rp <= rp - UM;
                        end else begin
                            rp        <= rp + UM;
                            pop_dado  <= mem_rdata;
                            pop_valid <= 1'b1;
                        end
                        estado <= CONCLUI;
                    end
                end
                CONCLUI: begin
                    op_ready <= 1'b1;
                    estado   <= IDLE;
                end
                default: begin
                    op_ready <= 1'b1;
                    mem_req  <= 1'b0;
                    estado   <= IDLE;
                end
            endcase
        end
    end

endmodule
